// File: rtl/seq_pkg.sv
// Shared definitions for the sample sequencer: FSM state encoding, sample
// width, mid-scale reset value and a counter-width helper.
package seq_pkg;

  localparam int SAMPLE_W = 10;
  localparam logic [SAMPLE_W-1:0] MIDSCALE = 10'd512;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ADC_REQ  = 3'd1,
    ST_ADC_WAIT = 3'd2,
    ST_PROC     = 3'd3,
    ST_DAC_WAIT = 3'd4,
    ST_DAC_LOAD = 3'd5
  } seq_state_e;

  // Bits needed to hold values 0..max_val, never less than one bit.
  function automatic int cnt_width(input int max_val);
    if (max_val < 2) begin
      return 1;
    end else begin
      return $clog2(max_val + 1);
    end
  endfunction

endpackage

// File: rtl/sample_sequencer_if.sv
// Bundle of the sequencer's control, ADC, processor and DAC-side signals.
// The master modport is the sequencer; the slave modport is its environment.
interface sample_sequencer_if;
  import seq_pkg::*;

  logic                enable;
  logic                adc_start;
  logic                adc_done;
  logic [SAMPLE_W-1:0] adc_data;
  logic [SAMPLE_W-1:0] data_in_q;
  logic                data_valid;
  logic                dac_busy;
  logic                dac_load;
  logic                overrun;
  logic                adc_err;
  logic                flag_clr;
  logic [2:0]          state_dbg;

  modport master (
    input  enable, adc_done, adc_data, dac_busy, flag_clr,
    output adc_start, data_in_q, data_valid, dac_load, overrun, adc_err, state_dbg
  );

  modport slave (
    output enable, adc_done, adc_data, dac_busy, flag_clr,
    input  adc_start, data_in_q, data_valid, dac_load, overrun, adc_err, state_dbg
  );

endinterface

// File: rtl/sample_tick_gen.sv
// Sample-rate divider: one-cycle tick every CLK_DIV sysclk cycles while
// enabled; the count is held at zero while disabled.
module sample_tick_gen #(
  parameter int CLK_DIV = 1000
) (
  input  logic sysclk,
  input  logic rst_n,
  input  logic enable,
  output logic tick
);

  localparam int CW = $clog2(CLK_DIV);
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt_r;

  // Divider counter, wraps after the terminal count.
  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= '0;
    end else if (!enable) begin
      cnt_r <= '0;
    end else if (cnt_r == LAST) begin
      cnt_r <= '0;
    end else begin
      cnt_r <= cnt_r + CW'(1);
    end
  end

  assign tick = enable && (cnt_r == LAST);

endmodule

// File: rtl/sample_sequencer.sv
// Per-sample frame controller: tick -> ADC request/capture -> processor
// latency -> DAC load, with sticky overrun and ADC-timeout flags.
module sample_sequencer
  import seq_pkg::*;
#(
  parameter int CLK_DIV     = 1000,
  parameter int PROC_LAT    = 2,
  parameter int ADC_TIMEOUT = 255
) (
  input logic                 sysclk,
  input logic                 rst_n,
  sample_sequencer_if.master  bus
);

  localparam int TW = cnt_width(ADC_TIMEOUT);
  localparam int LW = cnt_width(PROC_LAT);

  logic                tick_s;
  seq_state_e          state_r, state_nxt_s;
  logic [TW-1:0]       tcnt_r, tcnt_nxt_s;
  logic [LW-1:0]       lcnt_r, lcnt_nxt_s;
  logic [SAMPLE_W-1:0] data_r, data_nxt_s;
  logic                start_r, start_nxt_s;
  logic                valid_r, valid_nxt_s;
  logic                load_r, load_nxt_s;
  logic                overrun_r, adc_err_r;
  logic                err_set_s, ovr_set_s;

  sample_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
    .sysclk (sysclk),
    .rst_n  (rst_n),
    .enable (bus.enable),
    .tick   (tick_s)
  );

  // Next-state and next-output decode; strobes are computed one state
  // ahead so they appear registered in the state they belong to.
  always_comb begin
    state_nxt_s = state_r;
    tcnt_nxt_s  = tcnt_r;
    lcnt_nxt_s  = lcnt_r;
    data_nxt_s  = data_r;
    start_nxt_s = 1'b0;
    valid_nxt_s = 1'b0;
    load_nxt_s  = 1'b0;
    err_set_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (tick_s) begin
          state_nxt_s = ST_ADC_REQ;
          start_nxt_s = 1'b1;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_ADC_REQ: begin
        tcnt_nxt_s  = TW'(ADC_TIMEOUT);
        state_nxt_s = ST_ADC_WAIT;
      end
      ST_ADC_WAIT: begin
        if (bus.adc_done) begin
          data_nxt_s  = bus.adc_data;
          valid_nxt_s = 1'b1;
          lcnt_nxt_s  = LW'(PROC_LAT - 1);
          state_nxt_s = ST_PROC;
        end else if (tcnt_r <= TW'(1)) begin
          tcnt_nxt_s  = '0;
          err_set_s   = 1'b1;
          state_nxt_s = ST_IDLE;
        end else begin
          tcnt_nxt_s  = tcnt_r - TW'(1);
        end
      end
      ST_PROC: begin
        if (lcnt_r == '0) begin
          state_nxt_s = ST_DAC_WAIT;
        end else begin
          lcnt_nxt_s  = lcnt_r - LW'(1);
        end
      end
      ST_DAC_WAIT: begin
        if (!bus.dac_busy) begin
          state_nxt_s = ST_DAC_LOAD;
          load_nxt_s  = 1'b1;
        end else begin
          state_nxt_s = ST_DAC_WAIT;
        end
      end
      ST_DAC_LOAD: begin
        state_nxt_s = ST_IDLE;
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // A tick outside IDLE (including the cycle the FSM is heading back to
  // IDLE) is dropped and reported.
  assign ovr_set_s = tick_s && (state_r != ST_IDLE);

  // State, counters and registered outputs.
  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      tcnt_r  <= '0;
      lcnt_r  <= '0;
      data_r  <= MIDSCALE;
      start_r <= 1'b0;
      valid_r <= 1'b0;
      load_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      tcnt_r  <= tcnt_nxt_s;
      lcnt_r  <= lcnt_nxt_s;
      data_r  <= data_nxt_s;
      start_r <= start_nxt_s;
      valid_r <= valid_nxt_s;
      load_r  <= load_nxt_s;
    end
  end

  // Sticky flags; a clear wins over a same-cycle set.
  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      overrun_r <= 1'b0;
      adc_err_r <= 1'b0;
    end else if (bus.flag_clr) begin
      overrun_r <= 1'b0;
      adc_err_r <= 1'b0;
    end else begin
      overrun_r <= overrun_r | ovr_set_s;
      adc_err_r <= adc_err_r | err_set_s;
    end
  end

  assign bus.adc_start  = start_r;
  assign bus.data_in_q  = data_r;
  assign bus.data_valid = valid_r;
  assign bus.dac_load   = load_r;
  assign bus.overrun    = overrun_r;
  assign bus.adc_err    = adc_err_r;
  assign bus.state_dbg  = state_r;

endmodule

// File: doc/sample_sequencer.md
Name: sample_sequencer

Overview:
Per-sample frame controller for the audio path. It divides sysclk down to the sample rate, then for each sample requests an ADC conversion, captures the 10-bit ADC word, and presents it to the processor with a one-cycle data_valid. After a fixed processing latency it issues the DAC load strobe. Overrun and ADC timeout are reported as sticky flags.

Parameters:
CLK_DIV, 1000, sysclk cycles per sample tick (≥16)
PROC_LAT, 2, sysclk cycles from data_valid to processor output being stable (≥1)
ADC_TIMEOUT, 255, max cycles waiting for adc_done before abort (≥2)

Ports:
sysclk  in  1  system clock, all logic on rising edge
rst_n  in  1  asynchronous active-low reset
enable  in  1  1 = run sample frames; 0 = stop after current frame
adc_start  out  1  one-cycle conversion request to ADC interface
adc_done  in  1  one-cycle pulse, adc_data valid this cycle
adc_data  in  10  raw offset-binary ADC word
data_in_q  out  10  captured sample, feeds processor data_in
data_valid  out  1  one-cycle strobe to processor
dac_busy  in  1  DAC interface cannot accept load
dac_load  out  1  one-cycle strobe, DAC takes processor data_out
overrun  out  1  sticky: tick arrived while frame in progress
adc_err  out  1  sticky: ADC timeout occurred
flag_clr  in  1  clears overrun and adc_err
state_dbg  out  3  current state encoding

Behaviour:
- Reset: all outputs 0, data_in_q = 10'd512 (mid-scale), state IDLE, tick counter 0.
- Tick: counter 0..CLK_DIV-1 while enable=1; tick is high for the one cycle at count CLK_DIV-1, then wraps to 0. When enable=0, the counter is held at 0 and no tick is produced.
- States: IDLE=0, ADC_REQ=1, ADC_WAIT=2, PROC=3, DAC_WAIT=4, DAC_LOAD=5.
- IDLE: on tick → ADC_REQ.
- ADC_REQ: adc_start=1 for exactly this cycle. Load timeout counter with ADC_TIMEOUT. → ADC_WAIT.
- ADC_WAIT: adc_done is ignored in the ADC_REQ cycle.
  - adc_done=1: data_in_q<=adc_data and data_valid<=1 at the next edge, → PROC.
  - Otherwise the counter decrements. When it reaches 0: adc_err<=1 → IDLE, with no data_valid and no dac_load.
- PROC: stays exactly PROC_LAT cycles. data_valid is high only on the first PROC cycle. Then → DAC_WAIT.
- DAC_WAIT: if dac_busy=0 → DAC_LOAD; else wait with no timeout.
- DAC_LOAD: dac_load=1 for this cycle → IDLE.
- Latency: with tick at cycle T and adc_done at cycle D, the timing is:
  - adc_start at T+1
  - data_valid at D+1
  - DAC_WAIT entered at D+1+PROC_LAT
  - dac_load at D+2+PROC_LAT if dac_busy=0
- Overrun: a tick in any state other than IDLE sets overrun and is dropped. The current frame continues unaffected.
- Tick on the same cycle the FSM enters IDLE from DAC_LOAD or a timeout: the FSM is not yet in IDLE, so this is an overrun.
- flag_clr: clear has priority over a same-cycle set.
- enable deasserted mid-frame: the frame completes normally (including dac_load), then the FSM stays in IDLE.
- adc_done outside ADC_WAIT: ignored, no capture.
- rst_n low at any time: immediate return to reset values. A pending dac_load is never emitted.
- All outputs are registered.

Decomposition:
- Package seq_pkg: state encoding constants (3-bit), SAMPLE_W=10, MIDSCALE=10'd512.
- Sub-module sample_tick_gen (parameter CLK_DIV; ports sysclk, rst_n, enable, tick) for the divider.
- The FSM, timeout counter, latency counter and flags live in sample_sequencer.

Test Plan:
- Parameters CLK_DIV=16, PROC_LAT=2, ADC_TIMEOUT=8. Reset, then enable=1 → tick at cycle 15 and adc_start at cycle 16. Ticks repeat every 16 cycles.
- adc_done with adc_data=10'h3A5 at 3 cycles after adc_start → data_in_q=10'h3A5 and data_valid 1 cycle later. With dac_busy=0, dac_load 4 cycles after adc_done. Exactly one pulse of each.
- dac_busy=1 held for 20 cycles after DAC_WAIT is entered → a tick during the wait sets overrun. dac_load follows 1 cycle after dac_busy falls. flag_clr clears overrun.
- adc_done never asserted → adc_err=1 9 cycles after adc_start, with no data_valid and no dac_load. The next tick starts a fresh frame.
- enable dropped 1 cycle after adc_start → the frame completes with dac_load. There is no adc_start for ≥3×CLK_DIV cycles.
- rst_n pulsed low during PROC → outputs go to reset values immediately, data_in_q=512, and no dac_load is emitted. Normal frames resume after enable.
